hilo_muldiv_sequencer: RTL

//  Multi-cycle sequencer for the HI/LO multiply unit. Accepts ops issued by the
//  EX stage (mult, multu, madd, msub, mul, mthi, mtlo), runs an iterative

---
 rtl/hilo_muldiv_sequencer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative HI/LO multiply sequencer for the EX stage.
// Owns HI/LO, runs a shift-add multiply retiring STEP_BITS multiplier bits per
// cycle, and stalls the pipeline while an op is in flight.
// Optional build macro DIVIDER_EN adds DIV/DIVU (restoring divide, 1 bit/cycle).
module hilo_muldiv_sequencer #(
  parameter int unsigned STEP_BITS = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoRead,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] MulResult
);

  localparam int unsigned N     = 32 / STEP_BITS;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N - 1);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_MADD  = 4'b0010;
  localparam logic [3:0] OP_MSUB  = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef DIVIDER_EN
  localparam logic [3:0] OP_DIV   = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  // What the FIN cycle does with the finished product / quotient.
  typedef enum logic [2:0] {
    K_MULT,
    K_MADD,
    K_MSUB,
    K_MUL,
    K_DIV
  } kind_t;

  state_t           state;
  kind_t            kind;
  logic [CNT_W-1:0] cnt;
  logic             neg_p;
  logic [63:0]      mcand_sh;
  logic [31:0]      mplier;
  logic [63:0]      prod;
`ifdef DIVIDER_EN
  logic             neg_r;
  logic             div_zero;
`endif

  // Decode signals for the op presented this cycle
  logic        long_op;
  logic        op_signed;
  kind_t       op_kind;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Datapath next values for a RUN cycle
  logic [63:0] step_add;
  logic [63:0] prod_run;
  logic [63:0] mcand_run;
  logic [31:0] mplier_run;
`ifdef DIVIDER_EN
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] quo;
  logic [31:0] rem;
`endif

  // Results written at the FIN->IDLE edge
  logic [63:0] prod_fin;
  logic [63:0] fin_hilo;
  logic [31:0] fin_mr;

  // Pipeline freeze: any issue or HI/LO read while an op is in flight.
  assign Stall = Busy & (Start | HiLoRead);

  // Classify the incoming op and pick the magnitude operands.
  always_comb begin
    long_op   = 1'b0;
    op_signed = 1'b0;
    op_kind   = K_MULT;
    case (Op)
      OP_MULT: begin
        long_op   = 1'b1;
        op_signed = 1'b1;
      end
      OP_MULTU: begin
        long_op   = 1'b1;
      end
      OP_MADD: begin
        long_op   = 1'b1;
        op_signed = 1'b1;
        op_kind   = K_MADD;
      end
      OP_MSUB: begin
        long_op   = 1'b1;
        op_signed = 1'b1;
        op_kind   = K_MSUB;
      end
      OP_MUL: begin
        long_op   = 1'b1;
        op_signed = 1'b1;
        op_kind   = K_MUL;
      end
`ifdef DIVIDER_EN
      OP_DIV: begin
        long_op   = 1'b1;
        op_signed = 1'b1;
        op_kind   = K_DIV;
      end
      OP_DIVU: begin
        long_op   = 1'b1;
        op_kind   = K_DIV;
      end
`endif
      default: begin
      end
    endcase
    a_neg = op_signed & A[31];
    b_neg = op_signed & B[31];
    // 0x80000000 negates to itself, which read unsigned is the wanted 2^31.
    a_mag = a_neg ? (32'd0 - A) : A;
    b_mag = b_neg ? (32'd0 - B) : B;
  end

  // One RUN step: add the selected shifted multiplicands, or one divide bit.
  always_comb begin
    step_add = '0;
    for (int unsigned i = 0; i < STEP_BITS; i++) begin
      if (mplier[i]) begin
        step_add = step_add + (mcand_sh << i);
      end
    end
    prod_run   = prod + step_add;
    mcand_run  = mcand_sh << STEP_BITS;
    mplier_run = mplier >> STEP_BITS;
`ifdef DIVIDER_EN
    // prod holds {remainder, dividend/quotient}; mplier holds the divisor.
    div_shift = {prod[63:32], prod[31]};
    div_ge    = div_shift >= {1'b0, mplier};
    div_sub   = div_shift[31:0] - mplier;
    if (kind == K_DIV) begin
      mcand_run  = mcand_sh;
      mplier_run = mplier;
      prod_run   = div_ge ? {div_sub, prod[30:0], 1'b1}
                          : {div_shift[31:0], prod[30:0], 1'b0};
    end
`endif
  end

  // Sign-correct the result and merge it into HI/LO or MulResult.
  always_comb begin
    prod_fin = neg_p ? (64'd0 - prod) : prod;
    fin_hilo = {Hi, Lo};
    fin_mr   = MulResult;
`ifdef DIVIDER_EN
    quo = neg_p ? (32'd0 - prod[31:0]) : prod[31:0];
    rem = neg_r ? (32'd0 - prod[63:32]) : prod[63:32];
    if (div_zero) begin
      quo = 32'hFFFF_FFFF;
    end
`endif
    case (kind)
      K_MULT:  fin_hilo = prod_fin;
      K_MADD:  fin_hilo = {Hi, Lo} + prod_fin;
      K_MSUB:  fin_hilo = {Hi, Lo} - prod_fin;
      K_MUL:   fin_mr   = prod_fin[31:0];
`ifdef DIVIDER_EN
      K_DIV:   fin_hilo = {rem, quo};
`endif
      default: begin
      end
    endcase
  end

  // Sequencer FSM with HI/LO ownership and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      kind      <= K_MULT;
      cnt       <= '0;
      neg_p     <= 1'b0;
      mcand_sh  <= '0;
      mplier    <= '0;
      prod      <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      MulResult <= '0;
`ifdef DIVIDER_EN
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (long_op) begin
              state    <= S_RUN;
              Busy     <= 1'b1;
              kind     <= op_kind;
              neg_p    <= a_neg ^ b_neg;
              mcand_sh <= {32'd0, a_mag};
              mplier   <= b_mag;
              prod     <= '0;
              cnt      <= MUL_LAST;
`ifdef DIVIDER_EN
              neg_r    <= a_neg;
              div_zero <= (B == 32'd0);
              if (op_kind == K_DIV) begin
                prod <= {32'd0, a_mag};
                cnt  <= DIV_LAST;
              end
`endif
            end else if (Op == OP_MTHI) begin
              Hi <= A;
            end else if (Op == OP_MTLO) begin
              Lo <= A;
            end
          end
        end
        S_RUN: begin
          prod     <= prod_run;
          mcand_sh <= mcand_run;
          mplier   <= mplier_run;
          cnt      <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state     <= S_IDLE;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          Hi        <= fin_hilo[63:32];
          Lo        <= fin_hilo[31:0];
          MulResult <= fin_mr;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
